// File: rtl/instr_pkg.sv
// Shared definitions for the instruction loader: default geometry and the
// loader FSM state encoding.
package instr_pkg;

    localparam int INSTR_D = 12;
    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_RAM.sv
// Instruction store: one synchronous write port for the loader and one
// asynchronous read port for the core's fetch path.
module instr_RAM
    import instr_pkg::*;
#(
    parameter int D = INSTR_D,
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         wr_en_i,
    input  logic [D-1:0] wr_addr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic [D-1:0] rd_addr_i,
    output logic [W-1:0] rd_data_o
);

    logic [W-1:0] mem_q [2**D];

    // Contents deliberately survive reset so an aborted load keeps what it wrote.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_loader.sv
// Streams machine-code words into the instruction store and holds the core
// while a load is in flight. Requests that would run past the top are rejected.
module instr_loader
    import instr_pkg::*;
#(
    parameter int D = INSTR_D,
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_start,
    input  logic [D-1:0] load_base,
    input  logic [D:0]   load_len,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic [D-1:0] prog_ctr,
    output logic [W-1:0] mach_code,
    output logic         core_hold,
    output logic         load_busy,
    output logic         load_done,
    output logic         load_err
);

    localparam logic [D+1:0] DEPTH   = {2'b01, {D{1'b0}}};
    localparam logic [D:0]   LEN_ONE = {{D{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [D-1:0] addr_q, addr_d;
    logic [D:0]   remaining_q, remaining_d;
    logic         err_q, err_d;

    logic [D+1:0] end_addr;
    logic         req_fits;
    logic         xfer;

    // Two extra bits so base + len can be compared against the depth without overflow.
    assign end_addr = {2'b00, load_base} + {1'b0, load_len};
    assign req_fits = (end_addr <= DEPTH);
    assign xfer     = in_valid && (state_q == LOAD);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (!req_fits) begin
                        err_d = 1'b1;
                    end else if (load_len == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d      = load_base;
                        remaining_d = load_len;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign load_busy = (state_q == LOAD);
    assign core_hold = (state_q != IDLE);
    assign load_done = (state_q == DONE);
    assign load_err  = err_q;

    instr_RAM #(
        .D (D),
        .W (W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (xfer),
        .wr_addr_i (addr_q),
        .wr_data_i (in_data),
        .rd_addr_i (prog_ctr),
        .rd_data_o (mach_code)
    );

    // A load never carries more words than it was granted.
    a_remaining_nonzero: assert property (@(posedge clk) disable iff (reset)
        (state_q == LOAD) |-> (remaining_q != '0));

    a_done_single: assert property (@(posedge clk) disable iff (reset)
        load_done |=> !load_done);

endmodule
